// File: rtl/fifo_mux_out_if.sv
// Handshake and status bundle between the upstream mux stage and fifo_mux_out.
// slave  : FIFO side (consumes data_in/push/pop, drives read data and status)
// master : user side (drives data_in/push/pop, observes read data and status)
interface fifo_mux_out_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             fifo_error;

    modport slave (
        input  data_in, push, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count, fifo_error
    );

    modport master (
        output data_in, push, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count, fifo_error
    );
endinterface

// File: rtl/fifo_mux_out.sv
// Synchronous FIFO buffering the 2-bit output of the mux-with-memory stage.
// Ports:
//   clk      - rising-edge clock
//   reset_L  - asynchronous active-low reset
//   fifo_if  - slave modport: data_in/push/pop in; data_out, valid_out,
//              full, empty, almost_full, almost_empty, count, fifo_error out
// All outputs come straight from flops; status flags are registered from the
// next-state count so they never depend combinationally on push or pop.
module fifo_mux_out #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 6,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 reset_L,
    fifo_mux_out_if.slave        fifo_if
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             fifo_error_q, fifo_error_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             almost_full_q, almost_full_d;
    logic             almost_empty_q, almost_empty_d;

    logic             pop_ok;
    logic             push_ok;

    // Acceptance: a push into a full FIFO is allowed only when a pop frees a slot.
    always_comb begin
        pop_ok  = fifo_if.pop && !empty_q;
        push_ok = fifo_if.push && (!full_q || pop_ok);
    end

    // Next-state for pointers, occupancy, read data and flags.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        data_out_d     = data_out_q;
        valid_out_d    = 1'b0;
        fifo_error_d   = fifo_error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Overflow or underflow latches the error until reset.
        if ((fifo_if.push && !push_ok) || (fifo_if.pop && !pop_ok)) begin
            fifo_error_d = 1'b1;
        end

        full_d         = (count_d == CNT_W'(DEPTH));
        empty_d        = (count_d == CNT_W'(0));
        almost_full_d  = (count_d >= CNT_W'(AF_THRESH));
        almost_empty_d = (count_d <= CNT_W'(AE_THRESH));
    end

    // Control and status registers; reset values describe an empty FIFO.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            valid_out_q    <= 1'b0;
            fifo_error_q   <= 1'b0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            valid_out_q    <= valid_out_d;
            fifo_error_q   <= fifo_error_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= fifo_if.data_in;
        end
    end

    assign fifo_if.data_out     = data_out_q;
    assign fifo_if.valid_out    = valid_out_q;
    assign fifo_if.count        = count_q;
    assign fifo_if.fifo_error   = fifo_error_q;
    assign fifo_if.full         = full_q;
    assign fifo_if.empty        = empty_q;
    assign fifo_if.almost_full  = almost_full_q;
    assign fifo_if.almost_empty = almost_empty_q;

endmodule

// File: tb/tb_fifo_mux_out.sv
// Self-checking bench for fifo_mux_out: directed scenarios followed by random
// push/pop traffic, all compared against a queue-based reference model.
module tb_fifo_mux_out;
    localparam int unsigned WIDTH = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF_TH = 6;
    localparam int unsigned AE_TH = 2;

    logic clk;
    logic reset_L;

    fifo_mux_out_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

    fifo_mux_out #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_TH), .AE_THRESH(AE_TH)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .fifo_if (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] mq [$];
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_err;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // Compare every DUT output against the model.
    task automatic check_all(input string ctx);
        int sz;
        sz = mq.size();
        check({ctx, ".count"},        32'(bus_if.count),        32'(sz));
        check({ctx, ".full"},         32'(bus_if.full),         32'(sz == DEPTH));
        check({ctx, ".empty"},        32'(bus_if.empty),        32'(sz == 0));
        check({ctx, ".almost_full"},  32'(bus_if.almost_full),  32'(sz >= AF_TH));
        check({ctx, ".almost_empty"}, 32'(bus_if.almost_empty), 32'(sz <= AE_TH));
        check({ctx, ".valid_out"},    32'(bus_if.valid_out),    32'(m_valid));
        check({ctx, ".data_out"},     32'(bus_if.data_out),     32'(m_data));
        check({ctx, ".fifo_error"},   32'(bus_if.fifo_error),   32'(m_err));
    endtask

    // One clock cycle of traffic: drive on the falling edge, model the rising
    // edge, then compare just after it.
    task automatic cyc(input string ctx, input logic ph, input logic pp, input logic [WIDTH-1:0] d);
        logic pop_acc, push_acc;
        @(negedge clk);
        bus_if.push    = ph;
        bus_if.pop     = pp;
        bus_if.data_in = d;
        @(posedge clk);
        pop_acc  = pp && (mq.size() > 0);
        push_acc = ph && ((mq.size() < DEPTH) || pop_acc);
        m_valid  = pop_acc;
        if (pop_acc)  m_data = mq.pop_front();
        if (push_acc) mq.push_back(d);
        if ((ph && !push_acc) || (pp && !pop_acc)) m_err = 1'b1;
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clk);
        bus_if.push = 1'b0;
        bus_if.pop  = 1'b0;
        reset_L     = 1'b0;
        #1;
        model_reset();
        check_all(ctx);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] pat [8];
        int pct_push, pct_pop;

        pat = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        reset_L        = 1'b1;
        bus_if.push    = 1'b0;
        bus_if.pop     = 1'b0;
        bus_if.data_in = '0;
        model_reset();

        // Power-up reset, held across edges with traffic ignored
        #2 reset_L = 1'b0;
        #1 check_all("por");
        @(negedge clk);
        bus_if.push = 1'b1;
        bus_if.pop  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all("por_hold");
        @(negedge clk);
        bus_if.push = 1'b0;
        bus_if.pop  = 1'b0;
        reset_L     = 1'b1;

        // Basic ordering
        cyc("b_push0", 1'b1, 1'b0, 2'b01);
        cyc("b_push1", 1'b1, 1'b0, 2'b10);
        cyc("b_push2", 1'b1, 1'b0, 2'b11);
        repeat (3) cyc("b_pop", 1'b0, 1'b1, 2'b00);
        cyc("b_idle", 1'b0, 1'b0, 2'b00);

        // Fill, overflow, drain
        for (int i = 0; i < 8; i++) cyc("f_push", 1'b1, 1'b0, pat[i]);
        cyc("f_ovf", 1'b1, 1'b0, 2'b11);
        for (int i = 0; i < 8; i++) cyc("f_pop", 1'b0, 1'b1, 2'b00);
        cyc("f_unf", 1'b0, 1'b1, 2'b00);

        // Simultaneous push/pop while full
        do_reset("rst1");
        for (int i = 0; i < 8; i++) cyc("s_push", 1'b1, 1'b0, pat[i]);
        cyc("s_both_full", 1'b1, 1'b1, 2'b10);
        for (int i = 0; i < 8; i++) cyc("s_pop", 1'b0, 1'b1, 2'b00);

        // Simultaneous push/pop while empty
        do_reset("rst2");
        cyc("e_both_empty", 1'b1, 1'b1, 2'b11);
        cyc("e_pop", 1'b0, 1'b1, 2'b00);

        // Pointer wrap and threshold crossings
        do_reset("rst3");
        for (int i = 0; i < 5; i++) cyc("w_push5", 1'b1, 1'b0, 2'($urandom));
        for (int i = 0; i < 5; i++) cyc("w_pop5", 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 6; i++) cyc("w_push6", 1'b1, 1'b0, 2'($urandom));
        for (int i = 0; i < 6; i++) cyc("w_pop6", 1'b0, 1'b1, 2'b00);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) cyc("a_push", 1'b1, 1'b0, pat[i + 1]);
        #3 reset_L = 1'b0;
        #1;
        model_reset();
        check_all("a_async");
        @(negedge clk);
        bus_if.push    = 1'b1;
        bus_if.data_in = 2'b01;
        @(posedge clk);
        #1 check_all("a_hold");
        @(negedge clk);
        bus_if.push = 1'b0;
        reset_L     = 1'b1;
        cyc("a_pop_empty", 1'b0, 1'b1, 2'b00);
        cyc("a_push_new", 1'b1, 1'b0, 2'b10);
        cyc("a_pop_new", 1'b0, 1'b1, 2'b00);

        // Random traffic with phases biased toward filling or draining
        do_reset("rst4");
        pct_push = 50;
        pct_pop  = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                pct_push = int'($urandom_range(15, 85));
                pct_pop  = int'($urandom_range(15, 85));
            end
            cyc("rnd",
                1'($urandom_range(99, 0) < 32'(pct_push)),
                1'($urandom_range(99, 0) < 32'(pct_pop)),
                2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
